// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC and IF/ID, ID/EX, EX/MEM, MEM/WB
// latch enables and synchronous clears from halt, memory-wait, flush,
// load-use and fetch-wait conditions. All outputs are combinational from
// the state register and inputs, so decisions take effect in the same cycle.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN
// is defined; otherwise both counter outputs are tied to zero.
module pipeline_hazard_ctrl #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic            CLK,
    input  logic            sRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            exmem_dmemREN_l,
    input  logic            exmem_dmemWEN_l,
    input  logic            exmem_pcsrc_l,
    input  logic            idex_dmemREN_l,
    input  logic [REGW-1:0] idex_wsel_l,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic            memwb_hlt_l,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_sRST,
    output logic            idex_sRST,
    output logic            exmem_sRST,
    output logic            memwb_sRST,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef enum logic [1:0] {StRun, StLdStall, StFlush, StHalt} state_e;

    state_e state_q, state_d;
    logic   mem_wait;
    logic   load_use;
    logic   stall_ev;
    logic   flush_ev;

    assign mem_wait = (exmem_dmemREN_l | exmem_dmemWEN_l) & ~dhit;
    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = idex_dmemREN_l && (idex_wsel_l != '0) &&
                      ((idex_wsel_l == ifid_rs) || (idex_wsel_l == ifid_rt));

    // State register.
    always_ff @(posedge CLK) begin
        if (sRST) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Prioritised hazard decode: next state plus all latch controls.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_sRST  = 1'b0;
        idex_sRST  = 1'b0;
        exmem_sRST = 1'b0;
        memwb_sRST = 1'b0;
        halt       = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        if (sRST) begin
            ifid_sRST  = 1'b1;
            idex_sRST  = 1'b1;
            exmem_sRST = 1'b1;
            memwb_sRST = 1'b1;
            state_d    = StRun;
        end else if (state_q == StHalt) begin
            halt = 1'b1;
        end else if (memwb_hlt_l) begin
            // Let the HALT retire through MEM/WB, freeze everything upstream.
            memwb_en = 1'b1;
            state_d  = StHalt;
        end else if (mem_wait) begin
            stall_ev = 1'b1;
        end else if (exmem_pcsrc_l) begin
            // Flush wins over load-use: the dependent instruction is discarded.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_sRST  = 1'b1;
            idex_sRST  = 1'b1;
            exmem_sRST = 1'b1;
            flush_ev   = 1'b1;
            state_d    = StFlush;
        end else if (load_use && (state_q != StLdStall)) begin
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            idex_sRST = 1'b1;
            stall_ev  = 1'b1;
            state_d   = StLdStall;
        end else if (!ihit) begin
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            ifid_sRST = 1'b1;
            stall_ev  = 1'b1;
            state_d   = StRun;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            state_d  = StRun;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] stall_q;
    logic [CNTW-1:0] flush_q;

    // Saturating event counters; events never fire in HALT, so they freeze there.
    always_ff @(posedge CLK) begin
        if (sRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) begin
                stall_q <= stall_q + CntOne;
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + CntOne;
            end
        end
    end

    assign stall_cnt = sRST ? '0 : stall_q;
    assign flush_cnt = sRST ? '0 : flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
